// File: rtl/wb_std2pipe_bridge_if.sv
// rtl/wb_std2pipe_bridge_if.sv - Wishbone B4 signal bundle used on both sides of the std-to-pipelined bridge
// Parameters: aw address width, dw data width (multiple of 8)
// Request signals (master to slave): cyc, stb, we, adr, sel, dat_w
// Response signals (slave to master): dat_r, ack, err, stall
// Modports: master drives requests and samples responses; slave does the opposite
interface wb_std2pipe_bridge_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [aw-1:0]   adr;
    logic [dw/8-1:0] sel;
    logic [dw-1:0]   dat_w;
    logic [dw-1:0]   dat_r;
    logic            ack;
    logic            err;
    logic            stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/wb_std2pipe_bridge.sv
// rtl/wb_std2pipe_bridge.sv - classic Wishbone B4 master to pipelined Wishbone B4 slave bridge
// Parameters: aw address width, dw data width, timeout response timeout in cycles
// Optional feature macro: WB_STD2PIPE_TIMEOUT_EN (abort with s.err after timeout cycles without response)
// Ports:
//   clk  system clock for both sides
//   rst  synchronous reset, active-low
//   s    classic side (slave modport): one STB-held-until-ACK transfer at a time, one-cycle ack/err reply
//   m    pipelined side (master modport): one single-beat request honouring stall
// All outputs are registered.
module wb_std2pipe_bridge #(
    parameter int aw      = 32,
    parameter int dw      = 32,
    parameter int timeout = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_std2pipe_bridge_if.slave  s,
    wb_std2pipe_bridge_if.master m
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic            ack_d, err_d;
    logic            capture_req, capture_rd;
    logic            rsp_seen;

    logic            m_cyc_q, m_stb_q, m_we_q;
    logic [aw-1:0]   m_adr_q;
    logic [dw/8-1:0] m_sel_q;
    logic [dw-1:0]   m_dat_q;
    logic [dw-1:0]   s_dat_q;
    logic            s_ack_q, s_err_q;

    if (dw % 8 != 0 || timeout < 1) begin : g_bad_param
        $error("wb_std2pipe_bridge: dw must be a multiple of 8 and timeout at least 1");
    end

`ifdef WB_STD2PIPE_TIMEOUT_EN
    localparam int cw = $clog2(timeout + 1);
    logic [cw-1:0] cnt_q;
    logic          tmo_hit;

    // The transition to DONE happens on the edge where the count would reach
    // timeout, so s.err appears timeout cycles after entering REQ.
    assign tmo_hit = (cnt_q == cw'(timeout - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (capture_req) begin
            cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

    // A response only counts in REQ once the request is accepted (no stall).
    assign rsp_seen = (m.ack || m.err) && (state_q == WAIT || !m.stall);

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        capture_req = 1'b0;
        capture_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s.cyc && s.stb) begin
                    capture_req = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ, WAIT: begin
                if (!s.cyc) begin
                    // Master abandoned the cycle: no reply, late responses dropped in IDLE.
                    state_d = IDLE;
                end else if (rsp_seen) begin
                    state_d    = DONE;
                    err_d      = m.err;
                    ack_d      = m.ack && !m.err;
                    capture_rd = m.ack && !m.err && !m_we_q;
`ifdef WB_STD2PIPE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
`endif
                end else if (state_q == REQ && !m.stall) begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            m_cyc_q <= 1'b0;
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_adr_q <= '0;
            m_sel_q <= '0;
            m_dat_q <= '0;
            s_dat_q <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_cyc_q <= (state_d == REQ) || (state_d == WAIT);
            m_stb_q <= (state_d == REQ);
            s_ack_q <= ack_d;
            s_err_q <= err_d;
            if (capture_req) begin
                m_we_q  <= s.we;
                m_adr_q <= s.adr;
                m_sel_q <= s.sel;
                m_dat_q <= s.dat_w;
            end
            if (capture_rd) begin
                s_dat_q <= m.dat_r;
            end
        end
    end

    assign m.cyc   = m_cyc_q;
    assign m.stb   = m_stb_q;
    assign m.we    = m_we_q;
    assign m.adr   = m_adr_q;
    assign m.sel   = m_sel_q;
    assign m.dat_w = m_dat_q;

    assign s.dat_r = s_dat_q;
    assign s.ack   = s_ack_q;
    assign s.err   = s_err_q;
    // The classic side has no stall concept; transfers are paced by ack.
    assign s.stall = 1'b0;
endmodule

// File: tb/tb_wb_std2pipe_bridge.sv
// tb/tb_wb_std2pipe_bridge.sv - self-checking bench for wb_std2pipe_bridge
module tb_wb_std2pipe_bridge;
    localparam int aw  = 32;
    localparam int dw  = 32;
    localparam int sw  = dw / 8;
    localparam int tmo = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_std2pipe_bridge_if #(.aw(aw), .dw(dw)) s_bus ();
    wb_std2pipe_bridge_if #(.aw(aw), .dw(dw)) m_bus ();

    wb_std2pipe_bridge #(.aw(aw), .dw(dw), .timeout(tmo)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s_bus),
        .m   (m_bus)
    );

    int tests = 0;
    int fails = 0;
    logic [dw-1:0] model_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        s_bus.cyc   = 1'b0;
        s_bus.stb   = 1'b0;
        m_bus.ack   = 1'b0;
        m_bus.err   = 1'b0;
        m_bus.stall = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One classic transfer. Cycle 0 is the current cycle, where the master presents
    // the strobe. The slave stalls nstall cycles, accepts at cycle nstall+1 and
    // responds nwait cycles after acceptance; the master sees the reply one
    // cycle after the response. Returns in the cycle after the reply.
    task automatic xfer(input logic we, input logic [aw-1:0] adr, input logic [sw-1:0] sel,
                        input logic [dw-1:0] wdat, input int nstall, input int nwait,
                        input logic r_ack, input logic r_err, input logic [dw-1:0] rdat);
        int acc_cyc, rsp_cyc, lat, accepted;
        acc_cyc  = nstall + 1;
        rsp_cyc  = acc_cyc + nwait;
        lat      = rsp_cyc + 1;
        accepted = 0;
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
        s_bus.we    = we;
        s_bus.adr   = adr;
        s_bus.sel   = sel;
        s_bus.dat_w = wdat;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            m_bus.stall = (k <= nstall);
            m_bus.ack   = (k == rsp_cyc) && r_ack;
            m_bus.err   = (k == rsp_cyc) && r_err;
            m_bus.dat_r = (k == rsp_cyc) ? rdat : $urandom;
            if (k == lat && !we && r_ack && !r_err) model_rdata = rdat;
            @(negedge clk);
            check("m_cyc", m_bus.cyc, k < lat);
            check("m_stb", m_bus.stb, k <= acc_cyc);
            if (k <= acc_cyc) begin
                check("m_adr", m_bus.adr, adr);
                check("m_we", m_bus.we, we);
                check("m_sel", m_bus.sel, sel);
                check("m_dat_o", m_bus.dat_w, wdat);
            end
            if (m_bus.stb && !m_bus.stall) accepted++;
            check("s_ack", s_bus.ack, (k == lat) && !r_err);
            check("s_err", s_bus.err, (k == lat) && r_err);
            check("s_dat_o", s_bus.dat_r, model_rdata);
        end
        check("beats", accepted, 1);
        @(posedge clk);
        #1;
        quiet_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ack"}, s_bus.ack, 1'b0);
        check({tag, "_s_err"}, s_bus.err, 1'b0);
        check({tag, "_m_cyc"}, m_bus.cyc, 1'b0);
        check({tag, "_m_stb"}, m_bus.stb, 1'b0);
        check({tag, "_m_we"}, m_bus.we, 1'b0);
        check({tag, "_m_adr"}, m_bus.adr, 32'h0);
        check({tag, "_m_sel"}, m_bus.sel, 4'h0);
        check({tag, "_m_dat_o"}, m_bus.dat_w, 32'h0);
        check({tag, "_s_dat_o"}, s_bus.dat_r, 32'h0);
    endtask

    initial begin
        logic          r_we;
        logic [1:0]    kind;
        logic [dw-1:0] rd;

        quiet_inputs();
        s_bus.we    = 1'b0;
        s_bus.adr   = '0;
        s_bus.sel   = '0;
        s_bus.dat_w = '0;
        m_bus.dat_r = '0;

        // Reset state
        idle(3);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // Read, no stall, same-cycle ack
        xfer(1'b0, 32'h100, 4'hF, 32'h0, 0, 0, 1'b1, 1'b0, 32'hDEADBEEF);
        idle(2);

        // Write with 3 stall cycles, ack 2 cycles after acceptance
        xfer(1'b1, 32'h200, 4'b0011, 32'h12345678, 3, 2, 1'b1, 1'b0, 32'hA5A5A5A5);
        idle(2);

        // Four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'(i * 4), 4'hF, 32'h0, 0, i % 2, 1'b1, 1'b0, $urandom);
        end
        idle(2);

        // Error and ack together on a read: err wins, s_dat_o unchanged
        xfer(1'b0, 32'h300, 4'hF, 32'h0, 1, 1, 1'b1, 1'b1, 32'h0BADF00D);
        idle(1);

        // Abort in WAIT followed by a late ack
        s_bus.cyc = 1'b1;
        s_bus.stb = 1'b1;
        s_bus.we  = 1'b0;
        s_bus.adr = 32'h400;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_m_stb", m_bus.stb, 1'b1);
        @(posedge clk); #1;
        s_bus.cyc = 1'b0;
        s_bus.stb = 1'b0;
        @(negedge clk);
        check("abort_wait_m_cyc", m_bus.cyc, 1'b1);
        check("abort_wait_m_stb", m_bus.stb, 1'b0);
        @(posedge clk); #1;
        m_bus.ack   = 1'b1;
        m_bus.dat_r = 32'hFEEDFACE;
        @(negedge clk);
        check("abort_m_cyc", m_bus.cyc, 1'b0);
        check("abort_s_ack", s_bus.ack, 1'b0);
        @(posedge clk); #1;
        m_bus.ack = 1'b0;
        @(negedge clk);
        check("late_s_ack", s_bus.ack, 1'b0);
        check("late_s_err", s_bus.err, 1'b0);
        check("late_m_cyc", m_bus.cyc, 1'b0);
        check("late_s_dat_o", s_bus.dat_r, model_rdata);
        idle(1);

        // Reset while stalled in REQ
        s_bus.cyc   = 1'b1;
        s_bus.stb   = 1'b1;
        s_bus.we    = 1'b1;
        s_bus.adr   = 32'h500;
        s_bus.sel   = 4'hF;
        s_bus.dat_w = 32'hCAFEF00D;
        @(posedge clk); #1;
        m_bus.stall = 1'b1;
        @(negedge clk);
        check("rst_req_m_stb", m_bus.stb, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        quiet_inputs();
        model_rdata = '0;
        @(negedge clk);
        check_all_zero("midrst");
        idle(1);
        xfer(1'b0, 32'h600, 4'hF, 32'h0, 0, 1, 1'b1, 1'b0, 32'h13579BDF);
        idle(1);

        // Randomized transfers against the timing/response model
        for (int i = 0; i < 20; i++) begin
            r_we = 1'($urandom);
            kind = 2'($urandom_range(0, 2));
            rd   = $urandom;
            xfer(r_we, $urandom, 4'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 kind != 2'd1, kind != 2'd0, rd);
            idle($urandom_range(0, 2));
        end

        // Slave never responds
        s_bus.cyc = 1'b1;
        s_bus.stb = 1'b1;
        s_bus.we  = 1'b0;
        s_bus.adr = 32'h700;
`ifdef WB_STD2PIPE_TIMEOUT_EN
        for (int k = 1; k <= tmo + 1; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("tmo_m_cyc", m_bus.cyc, k <= tmo);
            check("tmo_s_err", s_bus.err, k == tmo + 1);
            check("tmo_s_ack", s_bus.ack, 1'b0);
            check("tmo_s_dat_o", s_bus.dat_r, model_rdata);
        end
        @(posedge clk); #1;
        quiet_inputs();
        @(negedge clk);
        check("tmo_after_s_err", s_bus.err, 1'b0);
`else
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hang_m_cyc", m_bus.cyc, 1'b1);
            check("hang_m_stb", m_bus.stb, k == 1);
            check("hang_s_ack", s_bus.ack, 1'b0);
            check("hang_s_err", s_bus.err, 1'b0);
        end
        quiet_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        check("hang_abort_m_cyc", m_bus.cyc, 1'b0);
`endif
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
